// File: rtl/time_display.sv
// time_display: double-dabble BCD conversion of the stop-watch seconds count,
// driving a scanned two-digit 7-segment display with a blinking RUNNING point.
module time_display #(
    parameter int TIME_W    = 5,
    parameter int SCAN_DIV  = 1,
    parameter int BLINK_DIV = 50
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic [TIME_W-1:0] time_i,
    input  logic [2:0]        mode_i,
    output logic [6:0]        seg_o,
    output logic [1:0]        an_o,
    output logic              dp_o,
    output logic              busy_o
);
    localparam int CW = $clog2(TIME_W + 1);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {C_IDLE, C_SHIFT, C_DONE} cstate_t;

    cstate_t           state_q, state_d;
    logic [TIME_W-1:0] cap_q, cap_d, sh_q, sh_d;
    logic [7:0]        bcd_q, bcd_d, adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        tens_q, tens_d, ones_q, ones_d, digit;
    logic              busy_q, busy_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [BW-1:0]     blink_q, blink_d;
    logic [1:0]        an_q, an_d;
    logic              phase_q, phase_d, dp_q, dp_d, scan_wrap, blink_wrap, mode_ok;
    logic [6:0]        seg_q, seg_d;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0: seg_lut = 7'h3F;
            4'd1: seg_lut = 7'h06;
            4'd2: seg_lut = 7'h5B;
            4'd3: seg_lut = 7'h4F;
            4'd4: seg_lut = 7'h66;
            4'd5: seg_lut = 7'h6D;
            4'd6: seg_lut = 7'h7D;
            4'd7: seg_lut = 7'h07;
            4'd8: seg_lut = 7'h7F;
            4'd9: seg_lut = 7'h6F;
            default: seg_lut = 7'h00;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        adj     = '0;
        case (state_q)
            C_IDLE: if (time_i != cap_q) begin
                cap_d   = time_i;
                sh_d    = time_i;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = C_SHIFT;
            end
            C_SHIFT: begin
                adj = {(bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4],
                       (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0]};
                {bcd_d, sh_d} = {adj, sh_q} << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(TIME_W - 1)) state_d = C_DONE;
            end
            C_DONE: begin
                tens_d  = bcd_q[7:4];
                ones_d  = bcd_q[3:0];
                state_d = C_IDLE;
            end
            default: state_d = C_IDLE;
        endcase
        busy_d = state_d != C_IDLE;
    end

    // seg/an/dp are all derived from the next digit select so they switch together
    always_comb begin
        scan_wrap  = scan_q == SW'(SCAN_DIV - 1);
        scan_d     = scan_wrap ? '0 : scan_q + SW'(1);
        an_d       = scan_wrap ? {an_q[0], an_q[1]} : an_q;
        blink_wrap = blink_q == BW'(BLINK_DIV - 1);
        blink_d    = blink_wrap ? '0 : blink_q + BW'(1);
        phase_d    = phase_q ^ blink_wrap;
        mode_ok    = (mode_i == 3'b100) || (mode_i == 3'b010) || (mode_i == 3'b001);
        digit      = an_d[1] ? tens_q : ones_q;
        seg_d      = !mode_ok ? 7'h40 : (an_d[1] && tens_q == 4'd0) ? 7'h00 : seg_lut(digit);
        dp_d       = (mode_i == 3'b001) && phase_d && an_d[0];
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= C_IDLE;
            cap_q   <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            scan_q  <= '0;
            an_q    <= 2'b01;
            blink_q <= '0;
            phase_q <= 1'b0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            scan_q  <= scan_d;
            an_q    <= an_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign seg_o  = seg_q;
    assign an_o   = an_q;
    assign dp_o   = dp_q;
    assign busy_o = busy_q;
endmodule

// File: tb/tb_time_display.sv
// tb_time_display: cycle model of time_display plus directed literal checks.
module tb_time_display;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] time_i = '0;
    logic [2:0] mode_i = 3'b100;
    logic [6:0] seg_o;
    logic [1:0] an_o;
    logic       dp_o, busy_o;

    int n_chk = 0, n_fail = 0;

    time_display dut (
        .clk(clk), .rst_i(rst_i), .time_i(time_i), .mode_i(mode_i),
        .seg_o(seg_o), .an_o(an_o), .dp_o(dp_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: display value changes 6 edges after a new value is latched; digit
    // select alternates each edge; blink phase is floor(edges/50) mod 2.
    logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         k, m_rem, m_tens, m_ones;
    logic [4:0] m_cap;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_dp, e_busy, mvalid = 1'b0;

    always @(posedge clk) begin
        if (rst_i) begin
            k = 0; m_rem = 0; m_cap = '0; m_tens = 0; m_ones = 0;
            e_seg = '0; e_an = 2'b01; e_dp = 1'b0; e_busy = 1'b0; mvalid = 1'b1;
        end else begin
            k++;
            e_an = (k % 2 == 1) ? 2'b10 : 2'b01;
            if (!(mode_i inside {3'b100, 3'b010, 3'b001})) e_seg = 7'h40;
            else if (e_an == 2'b10) e_seg = (m_tens == 0) ? 7'h00 : lut[m_tens];
            else e_seg = lut[m_ones];
            e_dp = (mode_i == 3'b001) && ((k / 50) % 2 == 1) && (e_an == 2'b01);
            if (m_rem == 0) begin
                if (time_i != m_cap) begin m_cap = time_i; m_rem = 6; end
            end else begin
                m_rem--;
                if (m_rem == 0) begin m_tens = m_cap / 10; m_ones = m_cap % 10; end
            end
            e_busy = m_rem != 0;
        end
    end

    always @(negedge clk) if (mvalid) begin
        chk("model_seg", seg_o, e_seg);
        chk("model_an", an_o, e_an);
        chk("model_dp", dp_o, e_dp);
        chk("model_busy", busy_o, e_busy);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input logic [6:0] t, input logic [6:0] o);
        repeat (2) begin
            @(negedge clk);
            if (an_o == 2'b10) chk("tens_seg", seg_o, t);
            else chk("ones_seg", seg_o, o);
        end
    endtask

    initial begin
        int cnt, bad;
        cyc(2);
        chk("rst_seg", seg_o, 0);
        chk("rst_an", an_o, 2'b01);
        rst_i = 1'b0;
        // idle at zero: tens blank, ones 0, never busy
        cnt = 0;
        repeat (4) begin @(negedge clk); cnt += busy_o; end
        chk("zero_busy", cnt, 0);
        show(7'h00, 7'h3F);
        // 0 -> 21
        time_i = 5'd21;
        cnt = 0;
        repeat (12) begin @(negedge clk); cnt += busy_o; end
        chk("busy_len_21", cnt, 6);
        show(7'h5B, 7'h06);
        time_i = 5'd9;  cyc(10); show(7'h00, 7'h6F);
        time_i = 5'd31; cyc(10); show(7'h4F, 7'h06);
        // RUNNING blink on the ones digit
        mode_i = 3'b001; time_i = 5'd5; cyc(10);
        show(7'h00, 7'h6D);
        cnt = 0; bad = 0;
        repeat (200) begin
            @(negedge clk);
            cnt += dp_o;
            if (dp_o && an_o == 2'b10) bad++;
        end
        chk("dp_cycles", cnt, 50);
        chk("dp_on_tens", bad, 0);
        mode_i = 3'b100;
        repeat (3) begin @(negedge clk); chk("dp_idle", dp_o, 0); end
        // back-to-back values: the later one wins
        time_i = 5'd17; cyc(1);
        time_i = 5'd25; cyc(16);
        show(7'h5B, 7'h6D);
        // invalid mode shows dashes
        mode_i = 3'b011;
        repeat (4) begin @(negedge clk); chk("dash_seg", seg_o, 7'h40); chk("dash_dp", dp_o, 0); end
        mode_i = 3'b100; time_i = 5'd0; cyc(10);
        show(7'h00, 7'h3F);
        // reset mid-conversion
        time_i = 5'd31; cyc(2);
        rst_i = 1'b1; cyc(1);
        chk("mid_rst_seg", seg_o, 0);
        chk("mid_rst_an", an_o, 2'b01);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_dp", dp_o, 0);
        rst_i = 1'b0; cyc(9);
        show(7'h4F, 7'h06);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
